// File: rtl/rv32i_types.sv
// ---------------------------------------------------------------------------
// rv32i_types
// Shared RV32I decode types for the ID stage:
//   opcode_e   - base-ISA major opcodes
//   imm_fmt_e  - immediate encoding formats
//   id_ex_t    - contents of the ID/EX pipeline register
//   is_rv32i_opcode() - legality check on a 7-bit opcode
// ---------------------------------------------------------------------------
package rv32i_types;

  typedef enum logic [6:0] {
    OPC_LUI      = 7'b0110111,
    OPC_AUIPC    = 7'b0010111,
    OPC_JAL      = 7'b1101111,
    OPC_JALR     = 7'b1100111,
    OPC_BRANCH   = 7'b1100011,
    OPC_LOAD     = 7'b0000011,
    OPC_STORE    = 7'b0100011,
    OPC_OP_IMM   = 7'b0010011,
    OPC_OP       = 7'b0110011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic        is_load;
    logic        illegal;
  } id_ex_t;

  function automatic logic is_rv32i_opcode(input logic [6:0] opc);
    logic legal;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// ---------------------------------------------------------------------------
// imm_gen
// Combinational immediate generator and opcode legality check.
// Ports:
//   instr_i   [31:0] instruction word
//   imm_o     [31:0] sign-extended immediate (0 for formats without one)
//   illegal_o        opcode is outside the RV32I base set
// ---------------------------------------------------------------------------
module imm_gen
  import rv32i_types::*;
(
  input  logic [31:0] instr_i,
  output logic [31:0] imm_o,
  output logic        illegal_o
);

  imm_fmt_e fmt;

  // Select the immediate format from the opcode.
  always_comb begin
    fmt = IMM_NONE;
    case (instr_i[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
  end

  // Reassemble the scattered immediate bits; sign always comes from bit 31.
  always_comb begin
    imm_o = 32'd0;
    case (fmt)
      IMM_I: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                      instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U: imm_o = {instr_i[31:12], 12'd0};
      IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                      instr_i[20], instr_i[30:21], 1'b0};
      default: imm_o = 32'd0;
    endcase
  end

  assign illegal_o = ~is_rv32i_opcode(instr_i[6:0]);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// RV32I decode stage: drives regfile read addresses, builds immediates,
// detects load-use hazards and owns the ID/EX pipeline register.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   if_valid_i/pc_i/instr_i   IF/ID register contents
//   rs1_addr_o, rs2_addr_o    regfile read addresses (combinational)
//   rs1_data_i, rs2_data_i    regfile read data
//   mem_stall_i               downstream stall, freezes ID/EX
//   ex_flush_i                redirect from EX, kills the ID instruction
//   id_stall_o                hold request to IF (combinational)
//   ex_*_o                    ID/EX register fields
//   bubble_count_o            number of load-use bubbles inserted
// ---------------------------------------------------------------------------
module id_ex_stage
  import rv32i_types::*;
#(
  parameter logic LOAD_USE_STALL = 1'b1,
  parameter int   CNT_WIDTH      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_valid_i,
  input  logic [31:0]          if_pc_i,
  input  logic [31:0]          if_instr_i,
  output logic [4:0]           rs1_addr_o,
  output logic [4:0]           rs2_addr_o,
  input  logic [31:0]          rs1_data_i,
  input  logic [31:0]          rs2_data_i,
  input  logic                 mem_stall_i,
  input  logic                 ex_flush_i,
  output logic                 id_stall_o,
  output logic                 ex_valid_o,
  output logic [31:0]          ex_pc_o,
  output logic [6:0]           ex_opcode_o,
  output logic [2:0]           ex_funct3_o,
  output logic [6:0]           ex_funct7_o,
  output logic [4:0]           ex_rd_o,
  output logic [4:0]           ex_rs1_o,
  output logic [4:0]           ex_rs2_o,
  output logic [31:0]          ex_rs1_data_o,
  output logic [31:0]          ex_rs2_data_o,
  output logic [31:0]          ex_imm_o,
  output logic                 ex_is_load_o,
  output logic                 ex_illegal_o,
  output logic [CNT_WIDTH-1:0] bubble_count_o
);

  id_ex_t                ex_q, ex_d;
  id_ex_t                dec;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic [31:0]           imm;
  logic                  illegal;
  logic                  uses_rs1, uses_rs2;
  logic                  hz;

  assign rs1_addr_o = if_instr_i[19:15];
  assign rs2_addr_o = if_instr_i[24:20];

  imm_gen u_imm_gen (
    .instr_i   (if_instr_i),
    .imm_o     (imm),
    .illegal_o (illegal)
  );

  // Which source registers the ID instruction actually reads.
  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (if_instr_i[6:0])
      OPC_LUI, OPC_AUIPC, OPC_JAL:  uses_rs1 = 1'b0;
      default:                      uses_rs1 = 1'b1;
    endcase
    case (if_instr_i[6:0])
      OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  end

  // Fully decoded ID/EX candidate built from the IF/ID instruction.
  always_comb begin
    dec          = '0;
    dec.valid    = if_valid_i;
    dec.pc       = if_pc_i;
    dec.opcode   = if_instr_i[6:0];
    dec.funct3   = if_instr_i[14:12];
    dec.funct7   = if_instr_i[31:25];
    dec.rd       = if_instr_i[11:7];
    dec.rs1      = if_instr_i[19:15];
    dec.rs2      = if_instr_i[24:20];
    dec.rs1_data = rs1_data_i;
    dec.rs2_data = rs2_data_i;
    dec.imm      = imm;
    dec.is_load  = (if_instr_i[6:0] == OPC_LOAD);
    dec.illegal  = illegal;
  end

  // x0 is excluded; a bubble/flush clears is_load and rd so it cannot re-trigger.
  assign hz = LOAD_USE_STALL && if_valid_i && ex_q.valid && ex_q.is_load &&
              (ex_q.rd != 5'd0) &&
              ((uses_rs1 && (rs1_addr_o == ex_q.rd)) ||
               (uses_rs2 && (rs2_addr_o == ex_q.rd)));

  // Next-state selection: mem_stall > ex_flush > hazard bubble > normal load.
  always_comb begin
    ex_d         = ex_q;
    bubble_cnt_d = bubble_cnt_q;
    id_stall_o   = 1'b0;
    if (rst_i) begin
      id_stall_o = 1'b0;
    end else if (mem_stall_i) begin
      id_stall_o = 1'b1;
    end else if (ex_flush_i) begin
      ex_d         = dec;
      ex_d.valid   = 1'b0;
      ex_d.is_load = 1'b0;
      ex_d.rd      = 5'd0;
    end else if (hz) begin
      ex_d         = dec;
      ex_d.valid   = 1'b0;
      ex_d.is_load = 1'b0;
      ex_d.rd      = 5'd0;
      id_stall_o   = 1'b1;
      bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
    end else begin
      ex_d = dec;
    end
  end

  // ID/EX register and bubble counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o     = ex_q.valid;
  assign ex_pc_o        = ex_q.pc;
  assign ex_opcode_o    = ex_q.opcode;
  assign ex_funct3_o    = ex_q.funct3;
  assign ex_funct7_o    = ex_q.funct7;
  assign ex_rd_o        = ex_q.rd;
  assign ex_rs1_o       = ex_q.rs1;
  assign ex_rs2_o       = ex_q.rs2;
  assign ex_rs1_data_o  = ex_q.rs1_data;
  assign ex_rs2_data_o  = ex_q.rs2_data;
  assign ex_imm_o       = ex_q.imm;
  assign ex_is_load_o   = ex_q.is_load;
  assign ex_illegal_o   = ex_q.illegal;
  assign bubble_count_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam logic [31:0] ADDI_M1   = 32'hFFF00093; // addi x1,x0,-1
  localparam logic [31:0] BEQ_M4    = 32'hFE000EE3; // beq x0,x0,-4
  localparam logic [31:0] LUI_X5    = 32'h123452B7; // lui x5,0x12345
  localparam logic [31:0] LW_X3     = 32'h0000A183; // lw x3,0(x1)
  localparam logic [31:0] LW_X0     = 32'h0000A003; // lw x0,0(x1)
  localparam logic [31:0] ADD_X4    = 32'h00218233; // add x4,x3,x2
  localparam logic [31:0] ADD_X4_X0 = 32'h00200233; // add x4,x0,x2
  localparam logic [31:0] LUI_X3    = 32'h000181B7; // lui x3,0x18 (rs1 field = 3)
  localparam logic [31:0] SW_X3     = 32'h0030A023; // sw x3,0(x1)
  localparam logic [31:0] LW_X5_X3  = 32'h0001A283; // lw x5,0(x3)
  localparam logic [31:0] ADD_X6    = 32'h00028333; // add x6,x5,x0
  localparam logic [31:0] ILLEGAL   = 32'h0000007F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, mem_stall, ex_flush;
  logic [31:0] if_pc, if_instr, rs1_data, rs2_data;
  logic [4:0]  rs1_addr, rs2_addr, ex_rd, ex_rs1, ex_rs2;
  logic        id_stall, ex_valid, ex_is_load, ex_illegal;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, bubble_count;
  logic [6:0]  ex_opcode, ex_funct7;
  logic [2:0]  ex_funct3;

  logic [4:0]  ns_rs1_addr, ns_rs2_addr, ns_ex_rd, ns_ex_rs1, ns_ex_rs2;
  logic        ns_id_stall, ns_ex_valid, ns_ex_is_load, ns_ex_illegal;
  logic [31:0] ns_ex_pc, ns_ex_rs1_data, ns_ex_rs2_data, ns_ex_imm, ns_bubble_count;
  logic [6:0]  ns_ex_opcode, ns_ex_funct7;
  logic [2:0]  ns_ex_funct3;

  id_ex_stage #(.LOAD_USE_STALL(1'b1), .CNT_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_pc_i(if_pc), .if_instr_i(if_instr),
    .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .mem_stall_i(mem_stall), .ex_flush_i(ex_flush), .id_stall_o(id_stall),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_opcode_o(ex_opcode), .ex_funct3_o(ex_funct3),
    .ex_funct7_o(ex_funct7), .ex_rd_o(ex_rd), .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2),
    .ex_rs1_data_o(ex_rs1_data), .ex_rs2_data_o(ex_rs2_data), .ex_imm_o(ex_imm),
    .ex_is_load_o(ex_is_load), .ex_illegal_o(ex_illegal), .bubble_count_o(bubble_count)
  );

  id_ex_stage #(.LOAD_USE_STALL(1'b0), .CNT_WIDTH(32)) dut_ns (
    .clk_i(clk), .rst_i(rst), .if_valid_i(if_valid), .if_pc_i(if_pc), .if_instr_i(if_instr),
    .rs1_addr_o(ns_rs1_addr), .rs2_addr_o(ns_rs2_addr), .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
    .mem_stall_i(mem_stall), .ex_flush_i(ex_flush), .id_stall_o(ns_id_stall),
    .ex_valid_o(ns_ex_valid), .ex_pc_o(ns_ex_pc), .ex_opcode_o(ns_ex_opcode), .ex_funct3_o(ns_ex_funct3),
    .ex_funct7_o(ns_ex_funct7), .ex_rd_o(ns_ex_rd), .ex_rs1_o(ns_ex_rs1), .ex_rs2_o(ns_ex_rs2),
    .ex_rs1_data_o(ns_ex_rs1_data), .ex_rs2_data_o(ns_ex_rs2_data), .ex_imm_o(ns_ex_imm),
    .ex_is_load_o(ns_ex_is_load), .ex_illegal_o(ns_ex_illegal), .bubble_count_o(ns_bubble_count)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] d1, d2, imm;
    logic        is_load, ill, full;
    logic [31:0] cnt;
  } exp_t;

  exp_t m;        // reference model of the ID/EX register
  exp_t sb[$];    // scoreboard
  int   errors = 0;
  int   checks = 0;
  logic last_stall, ns_last_stall;

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic signed [31:0] t;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin t = ins; return t >>> 20; end
      7'h23: begin t = ins; t = t >>> 20; return {t[31:5], ins[11:7]}; end
      7'h63: begin t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'd0}; return t >>> 19; end
      7'h37, 7'h17: return ins & 32'hFFFFF000;
      7'h6F: begin t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'd0}; return t >>> 11; end
      default: return 32'd0;
    endcase
  endfunction

  // One clock cycle: drive inputs, check combinational outputs, predict, clock, compare.
  task automatic step(input logic r, input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ms, input logic fl);
    exp_t e;
    logic hz, u1, u2, exp_stall;
    logic [6:0] opc;
    rst = r; if_valid = v; if_pc = pc; if_instr = ins;
    rs1_data = $urandom; rs2_data = $urandom; mem_stall = ms; ex_flush = fl;
    #1;
    opc = ins[6:0];
    u1 = !(opc == 7'h37 || opc == 7'h17 || opc == 7'h6F);
    u2 = (opc == 7'h63 || opc == 7'h23 || opc == 7'h33);
    hz = v && m.valid && m.is_load && (m.rd != 5'd0) &&
         ((u1 && ins[19:15] == m.rd) || (u2 && ins[24:20] == m.rd));
    exp_stall = r ? 1'b0 : ms ? 1'b1 : fl ? 1'b0 : hz;
    last_stall = id_stall; ns_last_stall = ns_id_stall;
    checks++;
    if (id_stall !== exp_stall) begin
      errors++; $display("FAIL id_stall: got %b expected %b (instr %h, t=%0t)", id_stall, exp_stall, ins, $time);
    end
    checks++;
    if ({rs1_addr, rs2_addr} !== {ins[19:15], ins[24:20]}) begin
      errors++; $display("FAIL rs_addr: got %0d/%0d expected %0d/%0d", rs1_addr, rs2_addr, ins[19:15], ins[24:20]);
    end
    e = m;
    if (r) begin
      e = '{default: '0}; e.full = 1'b1;
    end else if (!ms) begin
      e.valid = v; e.pc = pc; e.opc = opc; e.f3 = ins[14:12]; e.f7 = ins[31:25];
      e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.d1 = rs1_data; e.d2 = rs2_data;
      e.imm = ref_imm(ins); e.is_load = (opc == 7'h03); e.full = 1'b1;
      e.ill = !(opc inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
      if (fl || hz) begin e.valid = 1'b0; e.is_load = 1'b0; e.rd = 5'd0; e.full = 1'b0; end
      if (!fl && hz) e.cnt = m.cnt + 32'd1;
    end
    m = e;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if ({ex_valid, ex_is_load, ex_rd} !== {e.valid, e.is_load, e.rd}) begin
      errors++; $display("FAIL ctl: got v=%b ld=%b rd=%0d expected v=%b ld=%b rd=%0d (t=%0t)",
                         ex_valid, ex_is_load, ex_rd, e.valid, e.is_load, e.rd, $time);
    end
    checks++;
    if (bubble_count !== e.cnt) begin
      errors++; $display("FAIL bubble_count: got %0d expected %0d", bubble_count, e.cnt);
    end
    if (e.full) begin
      checks++;
      if ({ex_pc, ex_opcode, ex_funct3, ex_funct7, ex_rs1, ex_rs2} !== {e.pc, e.opc, e.f3, e.f7, e.rs1, e.rs2}) begin
        errors++; $display("FAIL fields: got pc=%h opc=%h rs=%0d/%0d expected pc=%h opc=%h rs=%0d/%0d",
                           ex_pc, ex_opcode, ex_rs1, ex_rs2, e.pc, e.opc, e.rs1, e.rs2);
      end
      checks++;
      if ({ex_rs1_data, ex_rs2_data, ex_imm, ex_illegal} !== {e.d1, e.d2, e.imm, e.ill}) begin
        errors++; $display("FAIL data: got %h %h imm=%h ill=%b expected %h %h imm=%h ill=%b",
                           ex_rs1_data, ex_rs2_data, ex_imm, ex_illegal, e.d1, e.d2, e.imm, e.ill);
      end
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 32'h80, ADDI_M1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h80, ADDI_M1, 1'b0, 1'b0);
    checks++;
    if ({ex_valid, bubble_count, last_stall} !== {1'b0, 32'd0, 1'b0}) begin
      errors++; $display("FAIL reset: got v=%b cnt=%0d stall=%b expected 0/0/0", ex_valid, bubble_count, last_stall);
    end
    step(1'b0, 1'b1, 32'h100, ADDI_M1, 1'b0, 1'b0);
    checks++;
    if ({ex_valid, ex_pc} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL first_latch: got v=%b pc=%h expected 1/00000100", ex_valid, ex_pc);
    end
  endtask

  task automatic test_imm();
    step(1'b0, 1'b1, 32'h104, ADDI_M1, 1'b0, 1'b0);
    checks++;
    if ({ex_imm, ex_rd} !== {32'hFFFFFFFF, 5'd1}) begin
      errors++; $display("FAIL imm_addi: got imm=%h rd=%0d expected ffffffff/1", ex_imm, ex_rd);
    end
    step(1'b0, 1'b1, 32'h108, BEQ_M4, 1'b0, 1'b0);
    checks++;
    if (ex_imm !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL imm_beq: got %h expected fffffffc", ex_imm);
    end
    step(1'b0, 1'b1, 32'h10C, LUI_X5, 1'b0, 1'b0);
    checks++;
    if (ex_imm !== 32'h12345000) begin
      errors++; $display("FAIL imm_lui: got %h expected 12345000", ex_imm);
    end
    step(1'b0, 1'b0, 32'h110, SW_X3, 1'b0, 1'b0);
    checks++;
    if (ex_valid !== 1'b0) begin
      errors++; $display("FAIL if_invalid: got ex_valid=%b expected 0", ex_valid);
    end
  endtask

  task automatic test_load_use();
    step(1'b0, 1'b1, 32'h200, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h204, ADD_X4, 1'b0, 1'b0);
    checks++;
    if ({last_stall, ex_valid, bubble_count} !== {1'b1, 1'b0, 32'd1}) begin
      errors++; $display("FAIL load_use_bubble: got stall=%b v=%b cnt=%0d expected 1/0/1", last_stall, ex_valid, bubble_count);
    end
    step(1'b0, 1'b1, 32'h204, ADD_X4, 1'b0, 1'b0);
    checks++;
    if ({last_stall, ex_valid, ex_rd, ex_pc} !== {1'b0, 1'b1, 5'd4, 32'h204}) begin
      errors++; $display("FAIL load_use_release: got stall=%b v=%b rd=%0d pc=%h expected 0/1/4/00000204",
                         last_stall, ex_valid, ex_rd, ex_pc);
    end
    step(1'b0, 1'b1, 32'h208, LW_X0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h20C, ADD_X4_X0, 1'b0, 1'b0);
    checks++;
    if (last_stall !== 1'b0) begin
      errors++; $display("FAIL x0_no_hazard: got stall=%b expected 0", last_stall);
    end
    step(1'b0, 1'b1, 32'h210, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h214, LUI_X3, 1'b0, 1'b0);
    checks++;
    if (last_stall !== 1'b0) begin
      errors++; $display("FAIL lui_no_hazard: got stall=%b expected 0", last_stall);
    end
    step(1'b0, 1'b1, 32'h218, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h21C, SW_X3, 1'b0, 1'b0);
    checks++;
    if ({last_stall, bubble_count} !== {1'b1, 32'd2}) begin
      errors++; $display("FAIL rs2_hazard: got stall=%b cnt=%0d expected 1/2", last_stall, bubble_count);
    end
    step(1'b0, 1'b1, 32'h21C, SW_X3, 1'b0, 1'b0);
  endtask

  task automatic test_flush();
    step(1'b0, 1'b1, 32'h300, ADDI_M1, 1'b0, 1'b1);
    checks++;
    if ({last_stall, ex_valid} !== {1'b0, 1'b0}) begin
      errors++; $display("FAIL flush: got stall=%b v=%b expected 0/0", last_stall, ex_valid);
    end
    step(1'b0, 1'b1, 32'h304, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h308, ADD_X4, 1'b0, 1'b1);
    checks++;
    if ({last_stall, ex_valid, bubble_count} !== {1'b0, 1'b0, 32'd2}) begin
      errors++; $display("FAIL flush_vs_hazard: got stall=%b v=%b cnt=%0d expected 0/0/2", last_stall, ex_valid, bubble_count);
    end
    step(1'b0, 1'b1, 32'h400, ADD_X4, 1'b0, 1'b0);
  endtask

  task automatic test_mem_stall();
    step(1'b0, 1'b1, 32'h500, LW_X3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 32'h504, ADD_X4, 1'b1, 1'b0);
      checks++;
      if ({last_stall, ex_valid, ex_is_load, ex_rd, ex_pc, bubble_count} !==
          {1'b1, 1'b1, 1'b1, 5'd3, 32'h500, 32'd2}) begin
        errors++; $display("FAIL mem_stall_hold: got stall=%b v=%b ld=%b rd=%0d pc=%h cnt=%0d expected 1/1/1/3/00000500/2",
                           last_stall, ex_valid, ex_is_load, ex_rd, ex_pc, bubble_count);
      end
    end
    step(1'b0, 1'b1, 32'h504, ADD_X4, 1'b0, 1'b0);
    checks++;
    if ({last_stall, ex_valid, bubble_count} !== {1'b1, 1'b0, 32'd3}) begin
      errors++; $display("FAIL mem_stall_then_bubble: got stall=%b v=%b cnt=%0d expected 1/0/3", last_stall, ex_valid, bubble_count);
    end
    step(1'b0, 1'b1, 32'h504, ADD_X4, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(1'b0, 1'b1, 32'h600, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h604, LW_X5_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h604, LW_X5_X3, 1'b0, 1'b0);
    checks++;
    if ({last_stall, ex_valid, ex_rd} !== {1'b0, 1'b1, 5'd5}) begin
      errors++; $display("FAIL b2b_single_stall: got stall=%b v=%b rd=%0d expected 0/1/5", last_stall, ex_valid, ex_rd);
    end
    step(1'b0, 1'b1, 32'h608, ADD_X6, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h608, ADD_X6, 1'b0, 1'b0);
    checks++;
    if ({ex_valid, ex_rd, bubble_count} !== {1'b1, 5'd6, 32'd5}) begin
      errors++; $display("FAIL b2b_second: got v=%b rd=%0d cnt=%0d expected 1/6/5", ex_valid, ex_rd, bubble_count);
    end
  endtask

  task automatic test_illegal();
    step(1'b0, 1'b1, 32'h700, ILLEGAL, 1'b0, 1'b0);
    checks++;
    if ({ex_illegal, ex_imm, ex_valid} !== {1'b1, 32'd0, 1'b1}) begin
      errors++; $display("FAIL illegal: got ill=%b imm=%h v=%b expected 1/00000000/1", ex_illegal, ex_imm, ex_valid);
    end
  endtask

  task automatic test_no_stall_param();
    step(1'b0, 1'b1, 32'h800, LW_X3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h804, ADD_X4, 1'b0, 1'b0);
    checks++;
    if ({ns_last_stall, ns_ex_valid, ns_ex_rd, ns_bubble_count} !== {1'b0, 1'b1, 5'd4, 32'd0}) begin
      errors++; $display("FAIL no_stall_param: got stall=%b v=%b rd=%0d cnt=%0d expected 0/1/4/0",
                         ns_last_stall, ns_ex_valid, ns_ex_rd, ns_bubble_count);
    end
    step(1'b0, 1'b1, 32'h804, ADD_X4, 1'b0, 1'b0);
  endtask

  initial begin
    m = '{default: '0};
    rst = 1'b1; if_valid = 1'b0; if_pc = 32'd0; if_instr = 32'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; mem_stall = 1'b0; ex_flush = 1'b0;
    @(negedge clk);
    test_reset();
    test_imm();
    test_load_use();
    test_flush();
    test_mem_stall();
    test_back_to_back();
    test_illegal();
    test_no_stall_param();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
